imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory from a byte stream: accepts a 16-bit word count followed by little-endian instruction bytes over a valid/ready handshake, assembles 32-bit words and drives the memory's write port at consecutive word addresses. Sits between the host/boot byte source (UART receiver or test bench) and the instruction memory's write side. Holds the core in reset while loading.

## Interface
- DEPTH, 64, instruction memory depth in words
- ADDR_W, 6, word-address width, equal to clog2(DEPTH)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- start  input  1  one-cycle pulse to begin a load; sampled only in IDLE
- byte_data  input  8  incoming stream byte
- byte_valid  input  1  byte_data is valid
- byte_ready  output  1  loader accepts byte this cycle
- mem_we  output  1  one-cycle instruction-memory write strobe
- mem_addr  output  ADDR_W  word address, aligned with mem_we
- mem_wdata  output  32  instruction word, aligned with mem_we
- core_hold  output  1  hold core in reset; equals busy
- busy  output  1  load in progress
- done  output  1  one-cycle pulse at end of load
- len_err  output  1  sticky: word count exceeded DEPTH
- csum_err  output  1  sticky: checksum mismatch (CSUM only)
- words_loaded  output  16  count of words written in current/last load

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (macro only), DONE.
- Byte accepted on a rising edge where byte_valid && byte_ready. byte_ready = 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in IDLE, DONE.
- IDLE: start → LEN_LO; clears len_err, csum_err, words_loaded, checksum accumulator. start while not IDLE ignored.
- LEN_LO/LEN_HI: byte 0 = N[7:0], byte 1 = N[15:8]. After LEN_HI: N == 0 → DONE (or CSUM); N > DEPTH → set len_err, → DONE, no writes; else → DATA.
- DATA: bytes packed LSB first (byte 0 → bits 7:0). On 4th byte: mem_we registered high next cycle with mem_addr = word index (0,1,2…), mem_wdata = assembled word; words_loaded increments same edge. After Nth word → CSUM or DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Byte-valid gaps are allowed anywhere; state and partial word hold.
- Reset mid-load: immediate return to IDLE, all outputs to reset values; words already written stay in memory; partial word discarded.

## Timing
- Reset values: byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_hold 0, busy 0, done 0, len_err 0, csum_err 0, words_loaded 0.
- start at edge t → busy/core_hold/byte_ready high from cycle t+1.
- Write latency: 4th byte accepted at edge k → mem_we high in cycle k+1 only; mem_addr/mem_wdata hold value afterwards until next write.
- Back-to-back words: minimum 4 cycles per write; no write stall, no byte_ready drop in DATA.
- End (no CSUM): last mem_we in cycle k+1, done high cycle k+2, busy low from cycle k+3. busy is high in the done cycle.
- Length error: LEN_HI accepted at edge k → done and len_err high in cycle k+1.
- Max load DEPTH words; mem_addr never wraps.

## Configuration
- IMEM_LOADER_CSUM_EN defined: CSUM state present; after the last data word (or N == 0) one extra byte is accepted and compared with the 8-bit modulo-256 sum of all data bytes; mismatch sets csum_err; then DONE. Writes already performed are not undone. Skipped on len_err.
- Undefined: no CSUM state, no accumulator; csum_err tied 0; DONE follows last word directly.

## Structure
- Package imem_loader_pkg: state enum type, BYTES_PER_WORD = 4, LEN_BYTES = 2, CSUM_W = 8.
- One sub-module: word_assembler (byte shift-in, 2-bit byte index, word-complete pulse, clear input).
- Top holds FSM, word counter, length register, checksum, output registers.

## Test plan
- Reset values: reset held 3 cycles mid-stream → all outputs 0, state IDLE, byte_ready 0.
- Basic load: start, bytes 02 00, 13 00 00 00, 93 00 10 00 → writes addr 0 = 0x00000013, addr 1 = 0x00100093; done one cycle after second mem_we; words_loaded = 2.
- Gapped valid: same stream with byte_valid low 0–3 random cycles between bytes → identical writes and data.
- Length error: N = 0x0041 (65) with DEPTH 64 → no mem_we, len_err = 1, done one cycle after LEN_HI byte.
- Full depth and reset mid-load: N = 64 → last write addr 63; repeat, reset after 10 words → 10 writes only, busy 0, next start reloads from addr 0.
- CSUM (macro on): data 13 00 00 00 with checksum 0x13 → csum_err 0; checksum 0x14 → csum_err 1, word still written, done asserted.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CSUM_EN adds the trailing checksum-byte state.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int CSUM_W         = 8;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 6
) ();
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes LSB-first into a 32-bit word; word_done flags the
// cycle the final byte arrives, with the complete word already on 'word'.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        accept,
    input  logic [7:0]                  byte_data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_done
);
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [BYTES_PER_WORD-1:0][7:0]  lanes_q, lanes_d;

    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        if (clear) begin
            idx_d = '0;
        end else if (accept) begin
            lanes_d[idx_q] = byte_data;
            idx_d          = idx_q + IDX_W'(1);
        end
    end

    assign word_done = accept && !clear && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    // Bypass the incoming byte so the word is complete in its final cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word[8*gi +: 8] = (accept && idx_q == IDX_W'(gi)) ? byte_data : lanes_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a length-prefixed byte stream, holding the
// core in reset meanwhile. IMEM_LOADER_CSUM_EN enables the checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_hold,
    output logic         busy,
    output logic         done,
    output logic         len_err,
    output logic         csum_err,
    output logic [15:0]  words_loaded
);
    localparam int                   LEN_W   = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0]     DEPTH_W = LEN_W'(DEPTH);
`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [15:0]        words_q, words_d;
    logic               len_err_q, len_err_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [CSUM_W-1:0]  csum_q, csum_d;
    logic               csum_err_q, csum_err_d;
`endif

    logic               byte_ready;
    logic               accept;
    logic               asm_accept;
    logic               asm_clear;
    logic               word_done;
    logic [31:0]        word;
    logic [LEN_W-1:0]   len_full;

    assign accept     = bus.byte_valid && byte_ready;
    assign asm_accept = accept && (state_q == ST_DATA);
    assign asm_clear  = (state_q == ST_IDLE);
    assign len_full   = {bus.byte_data, len_q[7:0]};

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .accept    (asm_accept),
        .byte_data (bus.byte_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // DATA exits the cycle after the last word's write strobe, so done trails it by one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LEN_LO;
            ST_LEN_LO: if (accept) state_d = ST_LEN_HI;
            ST_LEN_HI: if (accept) begin
                if (len_full == '0)         state_d = ST_AFTER_DATA;
                else if (len_full > DEPTH_W) state_d = ST_DONE;
                else                         state_d = ST_DATA;
            end
            ST_DATA:   if (words_q == len_q) state_d = ST_AFTER_DATA;
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM:   if (accept) state_d = ST_DONE;
`endif
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        core_hold = busy;
        done      = (state_q == ST_DONE);
        case (state_q)
            ST_LEN_LO, ST_LEN_HI: byte_ready = 1'b1;
            ST_DATA:              byte_ready = (words_q != len_q);
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM:              byte_ready = 1'b1;
`endif
            default:              byte_ready = 1'b0;
        endcase
    end

    always_comb begin
        len_d       = len_q;
        words_d     = words_q;
        len_err_d   = len_err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d      = csum_q;
        csum_err_d  = csum_err_q;
`endif
        if (state_q == ST_IDLE && start) begin
            words_d   = '0;
            len_err_d = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_d     = '0;
            csum_err_d = 1'b0;
`endif
        end
        if (accept && state_q == ST_LEN_LO) len_d[7:0] = bus.byte_data;
        if (accept && state_q == ST_LEN_HI) begin
            len_d = len_full;
            if (len_full > DEPTH_W) len_err_d = 1'b1;
        end
        if (word_done) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = words_q[ADDR_W-1:0];
            mem_wdata_d = word;
            words_d     = words_q + 16'd1;
        end
`ifdef IMEM_LOADER_CSUM_EN
        if (asm_accept) csum_d = csum_q + bus.byte_data;
        if (accept && state_q == ST_CSUM && bus.byte_data != csum_q) csum_err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            words_q     <= '0;
            len_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q      <= '0;
            csum_err_q  <= 1'b0;
`endif
        end else begin
            len_q       <= len_d;
            words_q     <= words_d;
            len_err_q   <= len_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q      <= csum_d;
            csum_err_q  <= csum_err_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign len_err        = len_err_q;
    assign words_loaded   = words_q;
`ifdef IMEM_LOADER_CSUM_EN
    assign csum_err       = csum_err_q;
`else
    assign csum_err       = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; honours IMEM_LOADER_CSUM_EN.
module tb_imem_loader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit len_err; bit csum_err; int words; int cyc; } dn_t;

    logic        clk, reset, start;
    logic        core_hold, busy, done, len_err, csum_err;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .len_err      (len_err),
        .csum_err     (csum_err),
        .words_loaded (words_loaded)
    );

    wr_t exp_wq[$];
    dn_t exp_dq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  wr_cnt = 0;
    bit  done_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and end-of-load records as the DUT presents them.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we) begin
                wr_cnt++;
                $display("write addr=%0d data=%08h", bus.mem_addr, bus.mem_wdata);
                if (exp_wq.size() == 0) begin
                    chk("unexpected_write", 32'(bus.mem_addr), 32'hffff_ffff);
                end else begin
                    wr_t e;
                    e = exp_wq.pop_front();
                    chk("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("write_data", bus.mem_wdata, e.data);
                    chk("words_at_write", 32'(words_loaded), 32'(e.addr) + 1);
                end
            end
            if (done_prev) chk("busy_after_done", 32'(busy), 0);
            if (done) begin
                done_cnt++;
                $display("done len_err=%0b csum_err=%0b words=%0d cycle=%0d",
                         len_err, csum_err, words_loaded, cyc);
                chk("busy_in_done", 32'(busy), 1);
                if (exp_dq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    dn_t d;
                    d = exp_dq.pop_front();
                    chk("done_len_err", 32'(len_err), 32'(d.len_err));
                    chk("done_csum_err", 32'(csum_err), 32'(d.csum_err));
                    chk("done_words", 32'(words_loaded), 32'(d.words));
                    chk("done_cycle", cyc, d.cyc);
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_core_hold"}, 32'(core_hold), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_len_err"}, 32'(len_err), 0);
        chk({tag, "_csum_err"}, 32'(csum_err), 0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 0);
    endtask

    // Called and returns at posedge+1. acc_cyc = cycle that follows the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc, output bit ok);
        bit r;
        repeat (gap) begin @(posedge clk); #1; end
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        ok = 1'b0;
        acc_cyc = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            r = bus.byte_ready;
            acc_cyc = cyc + 1;
            @(posedge clk); #1;
            if (r) ok = 1'b1;
        end
        bus.byte_valid = 1'b0;
        if (!ok) chk("byte_accept_timeout", 32'(ok), 1);
    endtask

    function automatic bq_t gen_load(input int n);
        bq_t s;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
`ifdef IMEM_LOADER_CSUM_EN
            begin
                logic [7:0] sum;
                sum = 8'h00;
                for (int i = 2; i < s.size(); i++) sum = sum + s[i];
                s.push_back(sum);
            end
`endif
        end
        return s;
    endfunction

    // Model: length prefix, little-endian words, consecutive addresses, optional checksum.
    task automatic run_load(input bq_t s, input int max_gap, input int abort_after);
        int n, acc, prev_done, d;
        bit err, ok, exp_csum_err;
        dn_t rec;
        n   = int'({s[1], s[0]});
        err = (n > DEPTH);
        exp_csum_err = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        if (!err) begin
            logic [7:0] sum;
            sum = 8'h00;
            for (int i = 0; i < 4 * n; i++) sum = sum + s[2 + i];
            exp_csum_err = (s[2 + 4 * n] != sum);
        end
`endif
        $display("load n=%0d bytes=%0d gap<=%0d abort=%0d", n, s.size(), max_gap, abort_after);
        prev_done = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("hold_after_start", 32'(core_hold), 1);
        chk("ready_after_start", 32'(bus.byte_ready), 1);
        acc = 0;
        for (int i = 0; i < s.size(); i++) begin
            if (i == abort_after) return;
            send_byte(s[i], $urandom_range(max_gap, 0), acc, ok);
            if (!ok) return;
            d = i - 2;
            if (!err && d >= 0 && d < 4 * n && d % 4 == 3) begin
                wr_t w;
                w.addr = ADDR_W'(d / 4);
                w.data = {s[i], s[i-1], s[i-2], s[i-3]};
                exp_wq.push_back(w);
            end
        end
        rec.len_err  = err;
        rec.csum_err = exp_csum_err;
        rec.words    = err ? 0 : n;
`ifdef IMEM_LOADER_CSUM_EN
        rec.cyc = acc;
`else
        rec.cyc = (n > 0 && !err) ? acc + 1 : acc;
`endif
        exp_dq.push_back(rec);
        for (int t = 0; t < 64 && done_cnt == prev_done; t++) @(negedge clk);
        chk("done_seen", 32'(done_cnt != prev_done), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t s;
        int  wr_before;
        reset = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
        s.push_back(8'hb6);
`endif
        run_load(s, 0, -1);
        run_load(s, 3, -1);

        s = '{8'h41, 8'h00};
        run_load(s, 2, -1);

        run_load(gen_load(DEPTH), 0, -1);

        wr_before = wr_cnt;
        run_load(gen_load(DEPTH), 1, 44);
        reset = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin
            check_idle_outputs("midreset");
            @(posedge clk); #1;
        end
        chk("abort_write_count", 32'(wr_cnt - wr_before), 10);
        chk("abort_pending_writes", 32'(exp_wq.size()), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_load(gen_load(3), 2, -1);

        for (int k = 0; k < 8; k++) begin
            s = gen_load($urandom_range(8, 0));
`ifdef IMEM_LOADER_CSUM_EN
            s[s.size() - 1] = s[s.size() - 1] + 8'($urandom_range(1, 0));
`endif
            run_load(s, 3, -1);
        end

`ifdef IMEM_LOADER_CSUM_EN
        s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_load(s, 1, -1);
        s[6] = 8'h14;
        run_load(s, 1, -1);
`endif

        chk("final_pending_writes", 32'(exp_wq.size()), 0);
        chk("final_pending_done", 32'(exp_dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
